// File: rtl/mips_pkg.sv
// ---------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the MEM/WB consumer end of the pipeline.
//   DATA_WIDTH_DEF / ADDR_WIDTH_DEF : default GPR width and index width
//   REG_ZERO / REG_RA               : hard-wired zero register and link register
//   wb_sel_t                        : which source feeds the write-back value
// ---------------------------------------------------------------------------
package mips_pkg;

   localparam int DATA_WIDTH_DEF = 32;
   localparam int ADDR_WIDTH_DEF = 5;

   localparam logic [4:0] REG_ZERO = 5'd0;
   localparam logic [4:0] REG_RA   = 5'd31;

   typedef enum logic [1:0] {
      WB_ALU  = 2'd0,
      WB_MEM  = 2'd1,
      WB_LINK = 2'd2
   } wb_sel_t;

endpackage

// File: rtl/wb_data_mux.sv
// ---------------------------------------------------------------------------
// wb_data_mux
// Purely combinational selection of the write-back value.
// Ports:
//   mem_to_reg_i     in  1           pick load data
//   link_i           in  1           pick link value (wins over mem_to_reg_i)
//   pc_plus_4_i      in  DATA_WIDTH  link value
//   read_data_mmry_i in  DATA_WIDTH  load data
//   alu_result_i     in  DATA_WIDTH  ALU result
//   wb_data_o        out DATA_WIDTH  selected write-back value
// ---------------------------------------------------------------------------
module wb_data_mux
   import mips_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
   input  logic                  mem_to_reg_i,
   input  logic                  link_i,
   input  logic [DATA_WIDTH-1:0] pc_plus_4_i,
   input  logic [DATA_WIDTH-1:0] read_data_mmry_i,
   input  logic [DATA_WIDTH-1:0] alu_result_i,
   output logic [DATA_WIDTH-1:0] wb_data_o
);

   wb_sel_t wb_sel;

   // Decode the two control bits into a source select. The link path
   // (jal/jalr) takes priority so a link instruction that also happens to
   // carry mem_to_reg still writes the return address.
   always_comb begin
      wb_sel = WB_ALU;
      if (link_i) begin
         wb_sel = WB_LINK;
      end else if (mem_to_reg_i) begin
         wb_sel = WB_MEM;
      end
   end

   // Steer the chosen source onto the write-back bus; the ALU result is the
   // fallback for any unused encoding.
   always_comb begin
      wb_data_o = alu_result_i;
      case (wb_sel)
         WB_LINK: wb_data_o = pc_plus_4_i;
         WB_MEM:  wb_data_o = read_data_mmry_i;
         default: wb_data_o = alu_result_i;
      endcase
   end

endmodule

// File: rtl/writeback_register_file.sv
// ---------------------------------------------------------------------------
// writeback_register_file
// WB-stage data select plus the 2**ADDR_WIDTH x DATA_WIDTH GPR file.
// Commits the selected value on the rising edge, serves two combinational
// read ports to ID, exports the write-back value for forwarding and counts
// committed writes.
// Ports:
//   clk, reset (async, active-high)
//   mem_to_reg_i, link_i, reg_write_i, write_register_i
//   pc_plus_4_i, read_data_mmry_i, alu_result_i
//   read_register_1_i/2_i -> read_data_1_o/2_o
//   wb_data_o      selected write-back value
//   write_count_o  number of committed GPR writes (wraps)
// Optional feature macro: REGFILE_BYPASS_EN
//   defined   : a same-cycle write to the read index is visible on the read
//               port (write-before-read)
//   undefined : reads return the pre-edge register contents
// ---------------------------------------------------------------------------
module writeback_register_file
   import mips_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  mem_to_reg_i,
   input  logic                  link_i,
   input  logic                  reg_write_i,
   input  logic [ADDR_WIDTH-1:0] write_register_i,
   input  logic [DATA_WIDTH-1:0] pc_plus_4_i,
   input  logic [DATA_WIDTH-1:0] read_data_mmry_i,
   input  logic [DATA_WIDTH-1:0] alu_result_i,
   input  logic [ADDR_WIDTH-1:0] read_register_1_i,
   input  logic [ADDR_WIDTH-1:0] read_register_2_i,
   output logic [DATA_WIDTH-1:0] read_data_1_o,
   output logic [DATA_WIDTH-1:0] read_data_2_o,
   output logic [DATA_WIDTH-1:0] wb_data_o,
   output logic [31:0]           write_count_o
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] wb_data;
   logic [DATA_WIDTH-1:0] gpr [DEPTH];
   logic [31:0]           write_count;
   logic                  commit;

   wb_data_mux #(
      .DATA_WIDTH(DATA_WIDTH)
   ) u_wb_data_mux (
      .mem_to_reg_i    (mem_to_reg_i),
      .link_i          (link_i),
      .pc_plus_4_i     (pc_plus_4_i),
      .read_data_mmry_i(read_data_mmry_i),
      .alu_result_i    (alu_result_i),
      .wb_data_o       (wb_data)
   );

   // A write only counts as a commit when enabled and not aimed at the
   // zero register; both the array update and the counter key off this.
   assign commit = reg_write_i && (write_register_i != ADDR_WIDTH'(REG_ZERO));

   // GPR array and commit counter. Entry 0 is cleared by reset and never
   // written afterwards, so it reads back as zero without a special case on
   // the read side. Reset wins over any write presented in the same cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            gpr[i] <= '0;
         end
         write_count <= '0;
      end else if (commit) begin
         gpr[write_register_i] <= wb_data;
         write_count           <= write_count + 32'd1;
      end
   end

`ifdef REGFILE_BYPASS_EN
   // Write-before-read: a matching in-flight commit is forwarded straight to
   // the read port so ID never sees stale data. Suppressed during reset so
   // the ports read the cleared file rather than a write that will be lost.
   assign read_data_1_o = (commit && !reset && (write_register_i == read_register_1_i))
                          ? wb_data : gpr[read_register_1_i];
   assign read_data_2_o = (commit && !reset && (write_register_i == read_register_2_i))
                          ? wb_data : gpr[read_register_2_i];
`else
   // Plain array reads; the hazard unit stalls ID on a WB/ID index match.
   assign read_data_1_o = gpr[read_register_1_i];
   assign read_data_2_o = gpr[read_register_2_i];
`endif

   assign wb_data_o     = wb_data;
   assign write_count_o = write_count;

endmodule

// File: tb/tb_writeback_register_file.sv
// ---------------------------------------------------------------------------
// tb_writeback_register_file
// Self-checking bench for writeback_register_file: directed scenarios plus a
// randomized run checked against a behavioural array model.
// Honours REGFILE_BYPASS_EN the same way as the design.
// ---------------------------------------------------------------------------
module tb_writeback_register_file;
   import mips_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        mem_to_reg_i;
   logic        link_i;
   logic        reg_write_i;
   logic [4:0]  write_register_i;
   logic [31:0] pc_plus_4_i;
   logic [31:0] read_data_mmry_i;
   logic [31:0] alu_result_i;
   logic [4:0]  read_register_1_i;
   logic [4:0]  read_register_2_i;
   logic [31:0] read_data_1_o;
   logic [31:0] read_data_2_o;
   logic [31:0] wb_data_o;
   logic [31:0] write_count_o;

   logic [31:0] refGpr [32];
   logic [31:0] refCount;
   int          checkCount = 0;
   int          errorCount = 0;

   writeback_register_file dut (
      .clk              (clk),
      .reset            (reset),
      .mem_to_reg_i     (mem_to_reg_i),
      .link_i           (link_i),
      .reg_write_i      (reg_write_i),
      .write_register_i (write_register_i),
      .pc_plus_4_i      (pc_plus_4_i),
      .read_data_mmry_i (read_data_mmry_i),
      .alu_result_i     (alu_result_i),
      .read_register_1_i(read_register_1_i),
      .read_register_2_i(read_register_2_i),
      .read_data_1_o    (read_data_1_o),
      .read_data_2_o    (read_data_2_o),
      .wb_data_o        (wb_data_o),
      .write_count_o    (write_count_o)
   );

   always #5 clk = ~clk;

   // Reference write-back value straight from the selection rule.
   function automatic logic [31:0] refWb();
      if (link_i)       return pc_plus_4_i;
      if (mem_to_reg_i) return read_data_mmry_i;
      return alu_result_i;
   endfunction

   // Reference read: zero register, optional same-cycle forwarding, array.
   function automatic logic [31:0] refRead(input logic [4:0] idx);
      if (reset || idx == 5'd0) return 32'd0;
`ifdef REGFILE_BYPASS_EN
      if (reg_write_i && write_register_i != 5'd0 && write_register_i == idx) return refWb();
`endif
      return refGpr[idx];
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
      end
   endtask

   task automatic checkAll(input string tag);
      checkOutput({tag, "_wb"},    wb_data_o,     refWb());
      checkOutput({tag, "_rd1"},   read_data_1_o, refRead(read_register_1_i));
      checkOutput({tag, "_rd2"},   read_data_2_o, refRead(read_register_2_i));
      checkOutput({tag, "_count"}, write_count_o, refCount);
   endtask

   // Drive one WB instruction plus read indices at the falling edge.
   task automatic applyStimulus(input logic rw, input logic [4:0] wr, input logic mem, input logic lnk,
                                input logic [31:0] pc, input logic [31:0] rd, input logic [31:0] alu,
                                input logic [4:0] r1, input logic [4:0] r2);
      @(negedge clk);
      reg_write_i       = rw;
      write_register_i  = wr;
      mem_to_reg_i      = mem;
      link_i            = lnk;
      pc_plus_4_i       = pc;
      read_data_mmry_i  = rd;
      alu_result_i      = alu;
      read_register_1_i = r1;
      read_register_2_i = r2;
      #1;
   endtask

   // Let the rising edge commit the staged instruction and mirror it.
   task automatic stepEdge();
      if (!reset && reg_write_i && write_register_i != 5'd0) begin
         refGpr[write_register_i] = refWb();
         refCount = refCount + 32'd1;
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [31:0] oldNine;
      for (int i = 0; i < 32; i++) refGpr[i] = 32'd0;
      refCount = 32'd0;
      reset = 1'b1;
      reg_write_i = 1'b0; write_register_i = 5'd0; mem_to_reg_i = 1'b0; link_i = 1'b0;
      pc_plus_4_i = '0; read_data_mmry_i = '0; alu_result_i = '0;
      read_register_1_i = 5'd3; read_register_2_i = 5'd17;
      #12;
      checkOutput("reset_count", write_count_o, 32'd0);
      checkOutput("reset_rd1",   read_data_1_o, 32'd0);
      checkOutput("reset_rd2",   read_data_2_o, 32'd0);
      @(negedge clk);
      reset = 1'b0;

      // Plain ALU commit to r8.
      applyStimulus(1'b1, 5'd8, 1'b0, 1'b0, 32'h0, 32'h0, 32'h1234_5678, 5'd8, 5'd0);
      checkAll("t2_pre");
      stepEdge();
      applyStimulus(1'b0, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 5'd8, 5'd0);
      checkOutput("t2_gpr8",  read_data_1_o, 32'h1234_5678);
      checkOutput("t2_count", write_count_o, 32'd1);

      // Write to r0 is dropped and not counted.
      applyStimulus(1'b1, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0, 32'hDEAD_BEEF, 5'd0, 5'd0);
      stepEdge();
      checkOutput("t3_gpr0",  read_data_1_o, 32'd0);
      checkOutput("t3_count", write_count_o, 32'd1);

      // Link wins over mem_to_reg; target is the return-address register.
      applyStimulus(1'b1, REG_RA, 1'b1, 1'b1, 32'h0040_0010, 32'hCAFE_0000, 32'h1111_1111, REG_RA, 5'd8);
      checkOutput("t4_wb", wb_data_o, 32'h0040_0010);
      stepEdge();
      checkOutput("t4_gpr31", read_data_1_o, 32'h0040_0010);

      // Same-cycle read/write hazard on r9 from both ports.
      applyStimulus(1'b1, 5'd9, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0BAD_0009, 5'd0, 5'd0);
      stepEdge();
      oldNine = 32'h0BAD_0009;
      applyStimulus(1'b1, 5'd9, 1'b1, 1'b0, 32'h0, 32'hA5A5_A5A5, 32'h0, 5'd9, 5'd9);
`ifdef REGFILE_BYPASS_EN
      checkOutput("t5_rd1_pre", read_data_1_o, 32'hA5A5_A5A5);
      checkOutput("t5_rd2_pre", read_data_2_o, 32'hA5A5_A5A5);
`else
      checkOutput("t5_rd1_pre", read_data_1_o, oldNine);
      checkOutput("t5_rd2_pre", read_data_2_o, oldNine);
`endif
      stepEdge();
      checkOutput("t5_rd1_post", read_data_1_o, 32'hA5A5_A5A5);

      // Randomized run against the array model.
      for (int n = 0; n < 400; n++) begin
         applyStimulus(1'($urandom), 5'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0),
                       $urandom, $urandom, $urandom, 5'($urandom), 5'($urandom));
         checkAll($sformatf("rand%0d", n));
         stepEdge();
      end

      // Fill r1..r31, then assert reset mid-cycle with a write staged.
      for (int r = 1; r < 32; r++) begin
         applyStimulus(1'b1, 5'(r), 1'b0, 1'b0, 32'h0, 32'h0, 32'h5000_0000 + 32'(r), 5'(r), 5'(r));
         stepEdge();
      end
      applyStimulus(1'b1, 5'd12, 1'b0, 1'b0, 32'h0, 32'h0, 32'h7777_7777, 5'd31, 5'd1);
      checkOutput("fill_r31", read_data_1_o, 32'h5000_001F);
      #1;
      reset = 1'b1;
      #1;
      for (int i = 0; i < 32; i++) refGpr[i] = 32'd0;
      refCount = 32'd0;
      checkAll("rst_async");
      for (int r = 1; r < 32; r++) begin
         read_register_1_i = 5'(r);
         #0.1;
         checkOutput($sformatf("rst_r%0d", r), read_data_1_o, 32'd0);
      end
      read_register_1_i = 5'd12;
      stepEdge();
      checkAll("rst_edge");
      @(negedge clk);
      reset = 1'b0;

      // Counter wrap from all-ones.
      applyStimulus(1'b1, 5'd4, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0000_0044, 5'd4, 5'd0);
      force dut.write_count = 32'hFFFF_FFFF;
      #1;
      release dut.write_count;
      #1;
      refCount = 32'hFFFF_FFFF;
      checkOutput("t6_preload", write_count_o, 32'hFFFF_FFFF);
      stepEdge();
      checkOutput("t6_wrap", write_count_o, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
